// File: rtl/apb_master_1553b.sv
// APB master bridging a valid/ready command channel to APB transfers and
// returning one response per transfer, with an optional ACCESS-phase timeout.
module apb_master_1553b #(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned STRB_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  APB_CLK,
  input  logic                  APB_RESET,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATAWIDTH-1:0]  cmd_addr,
  input  logic [DATAWIDTH-1:0]  cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATAWIDTH-1:0]  rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  // APB bus
  output logic                  APB_SEL,
  output logic                  APB_ENABLE,
  output logic                  APB_WRITE,
  output logic [DATAWIDTH-1:0]  APB_ADDR,
  output logic [DATAWIDTH-1:0]  APB_WDATA,
  output logic [STRB_WIDTH-1:0] APB_STRB,
  output logic [2:0]            APB_PROT,
  input  logic [DATAWIDTH-1:0]  APB_RDATA,
  input  logic                  APB_READY,
  input  logic                  APB_SLVERR
);

  localparam int unsigned WAIT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                cmd_fire;
  logic                rsp_fire;
  logic                timeout_hit;

  // A pending response blocks new commands, so the handshake edge can never accept.
  assign cmd_ready   = (state == IDLE) && !rsp_valid;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign rsp_fire    = rsp_valid && rsp_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge APB_CLK or posedge APB_RESET) begin
    if (APB_RESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      APB_SEL     <= 1'b0;
      APB_ENABLE  <= 1'b0;
      APB_WRITE   <= 1'b0;
      APB_ADDR    <= '0;
      APB_WDATA   <= '0;
      APB_STRB    <= '0;
      APB_PROT    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_fire) begin
            APB_SEL    <= 1'b1;
            APB_ENABLE <= 1'b0;
            APB_WRITE  <= cmd_write;
            APB_ADDR   <= cmd_addr;
            APB_WDATA  <= cmd_wdata;
            APB_STRB   <= cmd_strb;
            APB_PROT   <= cmd_prot;
            state      <= SETUP;
          end
        end

        SETUP: begin
          APB_ENABLE <= 1'b1;
          wait_cnt   <= '0;
          state      <= ACCESS;
        end

        ACCESS: begin
          // READY takes priority over a timeout firing on the same edge.
          if (APB_READY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= APB_WRITE ? '0 : APB_RDATA;
            rsp_slverr  <= APB_SLVERR;
            rsp_timeout <= 1'b0;
            APB_SEL     <= 1'b0;
            APB_ENABLE  <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            APB_SEL     <= 1'b0;
            APB_ENABLE  <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: begin
          APB_SEL    <= 1'b0;
          APB_ENABLE <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_1553b.sv
// Scoreboard bench for apb_master_1553b: drives commands and a scripted APB
// slave, queues expected responses and compares them at the rsp handshake.
module tb_apb_master_1553b;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;
  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          timeout;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [DW-1:0] cmd_addr, cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          apb_sel, apb_enable, apb_write;
  logic [DW-1:0] apb_addr, apb_wdata, apb_rdata;
  logic [SW-1:0] apb_strb;
  logic [2:0]    apb_prot;
  logic          apb_ready, apb_slverr;

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  apb_master_1553b #(
    .DATAWIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .APB_CLK(clk), .APB_RESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .APB_SEL(apb_sel), .APB_ENABLE(apb_enable), .APB_WRITE(apb_write),
    .APB_ADDR(apb_addr), .APB_WDATA(apb_wdata), .APB_STRB(apb_strb), .APB_PROT(apb_prot),
    .APB_RDATA(apb_rdata), .APB_READY(apb_ready), .APB_SLVERR(apb_slverr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return 1ns after the edge that accepts it.
  task automatic issue(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input logic [2:0] prot);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_write = ~wr;
    if (!ok) check("cmd_accept_bound", 64'd0, 64'd1);
  endtask

  // Full transfer: slave inserts `waits` wait states, then READY with rdata/slverr.
  task automatic do_xfer(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input logic [2:0] prot, input int waits,
                         input logic [DW-1:0] rdata, input logic slverr);
    int   en_cycles;
    bit   timed_out;
    rsp_t e;
    issue(wr, addr, wdata, strb, prot);
    check("setup_sel", apb_sel, 1);
    check("setup_en", apb_enable, 0);
    check("setup_addr", apb_addr, addr);
    check("setup_write", apb_write, wr);
    check("setup_wdata", apb_wdata, wdata);
    check("setup_strb", apb_strb, strb);
    check("setup_prot", apb_prot, prot);
    timed_out = (waits > int'(TO));
    e.rdata   = (wr || timed_out) ? '0 : rdata;
    e.slverr  = timed_out ? 1'b1 : slverr;
    e.timeout = timed_out;
    exp_q.push_back(e);
    tick();
    en_cycles = 0;
    for (int k = 0; k <= 20; k++) begin
      check("access_en", apb_enable, 1);
      check("access_addr", apb_addr, addr);
      en_cycles++;
      if (k == waits) begin
        apb_ready  = 1'b1;
        apb_rdata  = rdata;
        apb_slverr = slverr;
      end
      tick();
      apb_ready  = 1'b0;
      apb_rdata  = $urandom;
      apb_slverr = 1'b1;
      if (rsp_valid) break;
    end
    check("enable_cycles", en_cycles, timed_out ? TO + 1 : waits + 1);
    check("done_sel", apb_sel, 0);
    check("done_en", apb_enable, 0);
    check("done_rsp_valid", rsp_valid, 1);
    check("idle_addr_kept", apb_addr, addr);
    check("idle_wdata_kept", apb_wdata, wdata);
  endtask

  // Hold rsp_ready low for `hold` cycles, then handshake and score the response.
  task automatic consume(input int hold);
    logic [DW-1:0] rd0, addr0;
    logic          se0, to0;
    rsp_t          e;
    rd0   = rsp_rdata;
    se0   = rsp_slverr;
    to0   = rsp_timeout;
    addr0 = apb_addr;
    check("consume_valid", rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_stable", {rsp_rdata, rsp_slverr, rsp_timeout}, {rd0, se0, to0});
      check("hold_addr", apb_addr, addr0);
    end
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_slverr", rsp_slverr, e.slverr);
      check("rsp_timeout", rsp_timeout, e.timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    cmd_strb   = '0;
    cmd_prot   = '0;
    rsp_ready  = 1'b0;
    apb_rdata  = '0;
    apb_ready  = 1'b0;
    apb_slverr = 1'b0;
    #1;
    check("rst_sel", apb_sel, 0);
    check("rst_en", apb_enable, 0);
    check("rst_addr", apb_addr, 0);
    check("rst_rsp", {rsp_valid, rsp_slverr, rsp_timeout, rsp_rdata}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);

    // zero-wait write
    do_xfer(1'b1, 32'h0000_000C, 32'h00AB_CDEF, 8'hFF, 3'd0, 0, 32'hDEAD_BEEF, 1'b0);
    consume(0);
    // read with three wait states
    do_xfer(1'b0, 32'h0000_0008, 32'h0, 8'h00, 3'd2, 3, 32'h8012_3456, 1'b0);
    consume(2);
    // slave never ready: timeout abort
    do_xfer(1'b0, 32'h0000_0010, 32'h0, 8'h0F, 3'd1, 10, 32'h1111_1111, 1'b0);
    consume(0);
    // READY on the edge the timeout would fire
    do_xfer(1'b0, 32'h0000_0014, 32'h0, 8'h0F, 3'd5, int'(TO), 32'h5A5A_A5A5, 1'b0);
    consume(0);
    // slave error on a write
    do_xfer(1'b1, 32'h0000_0018, 32'h1234_5678, 8'h33, 3'd7, 1, 32'hFFFF_FFFF, 1'b1);
    consume(0);

    // response back-pressure with a command already pending
    do_xfer(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 8'hAA, 3'd3, 0, 32'h0, 1'b0);
    cmd_valid = 1'b1;
    consume(10);
    check("no_accept_on_handshake", apb_sel, 0);
    check("ready_after_handshake", cmd_ready, 1);
    do_xfer(1'b0, 32'h0000_0024, 32'h0, 8'h01, 3'd4, 2, 32'h0BAD_CAFE, 1'b1);
    consume(0);

    for (int n = 0; n < 4; n++) begin
      do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom), 3'($urandom),
              int'($urandom_range(0, TO)), $urandom, 1'($urandom_range(0, 1)));
      consume(int'($urandom_range(0, 3)));
    end

    // reset in the middle of ACCESS
    issue(1'b1, 32'h0000_0030, 32'h7777_8888, 8'hF0, 3'd6);
    tick();
    check("pre_rst_en", apb_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", apb_sel, 0);
    check("async_rst_en", apb_enable, 0);
    check("async_rst_addr", apb_addr, 0);
    check("async_rst_rsp", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_cmd_ready", cmd_ready, 1);
    tick();
    tick();
    check("post_rst_no_rsp", rsp_valid, 0);
    check("post_rst_sel", apb_sel, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
